// File: rtl/gray_counter.sv
// Registered binary-to-Gray up/down counter with synchronous load and boundary pulse.
// Define GRAY_CNT_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [0:WIDTH-1] load_bin,
    output logic [0:WIDTH-1] bin,
    output logic [0:WIDTH-1] gray,
    output logic             wrap
);

    logic [0:WIDTH-1] next_bin;
    logic             next_wrap;
    logic             at_max;
    logic             at_zero;
    logic             at_boundary;

    // Index 0 is the MSB, so a numeric right shift pairs each bit with its upper neighbour.
    function automatic logic [0:WIDTH-1] encode(input logic [0:WIDTH-1] b);
        return b ^ (b >> 1);
    endfunction

    assign at_max      = &bin;
    assign at_zero     = ~|bin;
    assign at_boundary = up ? at_max : at_zero;

    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_bin;
        end else if (en) begin
            next_wrap = at_boundary;
`ifdef GRAY_CNT_SAT_EN
            if (!at_boundary) begin
                next_bin = up ? bin + 1'b1 : bin - 1'b1;
            end
`else
            next_bin = up ? bin + 1'b1 : bin - 1'b1;
`endif
        end
    end

    // Gray is encoded from next_bin so both outputs move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= encode(next_bin);
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a reflected-Gray reference model feeds an
// expectation queue that a free-running monitor drains one entry per clock.
module tb_gray_counter;

    localparam int W      = 4;
    localparam int MAXVAL = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [0:W-1] load_bin;
    logic [0:W-1] bin;
    logic [0:W-1] gray;
    logic         wrap;

    typedef struct {
        logic [0:W-1] bin;
        logic [0:W-1] gray;
        logic         wrap;
        logic         gray_moves;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int model_count = 0;
    int gray_table[0:MAXVAL];

    logic [0:W-1] prev_gray;

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build the Gray sequence by reflection: each new bit doubles the list mirrored.
    initial begin
        gray_table[0] = 0;
        for (int n = 0; n < W; n++) begin
            for (int k = 0; k < (1 << n); k++) begin
                gray_table[(1 << n) + k] = gray_table[(1 << n) - 1 - k] + (1 << n);
            end
        end
    end

    task automatic compare(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model, queue the expectation.
    task automatic applyStimulus(input logic r, input logic l, input logic [0:W-1] lb,
                                 input logic e, input logic u);
        exp_t x;
        @(negedge clk);
        rst      = r;
        load     = l;
        load_bin = lb;
        en       = e;
        up       = u;
        x.wrap       = 1'b0;
        x.gray_moves = 1'b0;
        if (r) begin
            model_count = 0;
        end else if (l) begin
            model_count = int'(lb);
        end else if (e) begin
            if (u && model_count == MAXVAL) begin
                x.wrap = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                model_count = MAXVAL;
`else
                model_count = 0;
`endif
            end else if (!u && model_count == 0) begin
                x.wrap = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                model_count = 0;
`else
                model_count = MAXVAL;
`endif
            end else begin
                model_count = u ? model_count + 1 : model_count - 1;
            end
`ifdef GRAY_CNT_SAT_EN
            x.gray_moves = !x.wrap;
`else
            x.gray_moves = 1'b1;
`endif
        end
        x.bin  = W'(model_count);
        x.gray = W'(gray_table[model_count]);
        exp_q.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        int decoded;
        int acc;
        compare("bin", int'(bin), int'(x.bin));
        compare("gray", int'(gray), int'(x.gray));
        compare("wrap", int'(wrap), int'(x.wrap));
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        decoded = 0;
        acc     = 0;
        for (int i = 0; i < W; i++) begin
            acc     = acc ^ int'(gray[i]);
            decoded = (decoded << 1) | acc;
        end
        compare("gray_decode", decoded, int'(bin));
        if (x.gray_moves) begin
            compare("gray_hamming", $countones(gray ^ prev_gray), 1);
        end
        prev_gray = gray;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        int budget;
        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_bin = '0;
        prev_gray = '0;

        // Reset then five up steps.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Full sweep from zero, crossing the top once.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Down across zero, then one more down step.
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Load beats enable; reset beats load.
        applyStimulus(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'b1010, 1'b1, 1'b1);

        // Reset mid-count while enabled, then resume from zero.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Top boundary twice, then back down; also hold cycles.
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Alternate direction across zero: every step is a boundary event.
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, i[0]);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 10,
                          W'($urandom),
                          $urandom_range(0, 99) < 75,
                          1'($urandom));
        end

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
